// File: rtl/pipe_ctrl_chain_if.sv
// Bundle of decode-side inputs and pipeline status outputs for the control chain.
// The decode/issue side drives through master; the chain itself uses slave.
interface pipe_ctrl_chain_if #(
    parameter int CTRL_W  = 21,
    parameter int NSTAGES = 3,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16
);
    localparam int FW = $clog2(NSTAGES + 1);

    logic                      id_valid;
    logic [CTRL_W-1:0]         id_ctrl;
    logic [REG_AW-1:0]         id_rs;
    logic [REG_AW-1:0]         id_rt;
    logic                      id_use_rs;
    logic                      id_use_rt;
    logic [REG_AW-1:0]         id_rd;
    logic                      id_wen;
    logic                      id_load;
    logic                      flush;
    logic                      stall_ext;
    logic                      stall;
    logic [NSTAGES-1:0]        stg_valid;
    logic [NSTAGES*CTRL_W-1:0] stg_ctrl;
    logic [FW-1:0]             fwd_a_sel;
    logic [FW-1:0]             fwd_b_sel;
    logic                      wb_wen;
    logic [REG_AW-1:0]         wb_rd;
    logic [CNT_W-1:0]          hz_count;

    modport master (
        output id_valid, id_ctrl, id_rs, id_rt, id_use_rs, id_use_rt,
               id_rd, id_wen, id_load, flush, stall_ext,
        input  stall, stg_valid, stg_ctrl, fwd_a_sel, fwd_b_sel,
               wb_wen, wb_rd, hz_count
    );

    modport slave (
        input  id_valid, id_ctrl, id_rs, id_rt, id_use_rs, id_use_rt,
               id_rd, id_wen, id_load, flush, stall_ext,
        output stall, stg_valid, stg_ctrl, fwd_a_sel, fwd_b_sel,
               wb_wen, wb_rd, hz_count
    );
endinterface

// File: rtl/pipe_ctrl_chain.sv
// Post-decode control pipeline (stage 0 = EX, last = WB) with load-use stall,
// flush, external freeze, operand forwarding selects and a saturating stall counter.
module pipe_ctrl_chain #(
    parameter int CTRL_W  = 21,
    parameter int NSTAGES = 3,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_chain_if.slave bus
);
    localparam int FW = $clog2(NSTAGES + 1);

    logic [NSTAGES-1:0]             valid_r;
    logic [NSTAGES-1:0][CTRL_W-1:0] ctrl_r;
    logic [NSTAGES-1:0][REG_AW-1:0] rd_r;
    logic [NSTAGES-1:0]             wen_r;
    // Load flag is only consulted in EX (hazard) and stage 1 (forward eligibility)
    logic [1:0]                     load_r;
    logic [REG_AW-1:0]              rs0_r;
    logic [REG_AW-1:0]              rt0_r;
    logic                           use_rs0_r;
    logic                           use_rt0_r;
    logic [CNT_W-1:0]               hz_count_r;

    logic                           hazard_s;
    logic                           accept_s;
    logic                           count_s;
    logic [FW-1:0]                  fwd_a_s;
    logic [FW-1:0]                  fwd_b_s;

    // Load-use hazard: EX holds a load whose result the decode instruction needs
    always_comb begin
        hazard_s = 1'b0;
        hazard_s = valid_r[0] && load_r[0] && wen_r[0] && (rd_r[0] != {REG_AW{1'b0}})
                   && bus.id_valid
                   && ((bus.id_use_rs && (bus.id_rs == rd_r[0]))
                       || (bus.id_use_rt && (bus.id_rt == rd_r[0])));
    end

    assign accept_s = bus.id_valid & ~bus.flush & ~hazard_s;
    assign count_s  = hazard_s & ~bus.flush;

    // Stage registers: freeze > flush > hazard bubble > normal advance
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_r    <= '0;
            ctrl_r     <= '0;
            rd_r       <= '0;
            wen_r      <= '0;
            load_r     <= 2'b00;
            rs0_r      <= '0;
            rt0_r      <= '0;
            use_rs0_r  <= 1'b0;
            use_rt0_r  <= 1'b0;
            hz_count_r <= '0;
        end else if (bus.stall_ext) begin
            valid_r    <= valid_r;
            hz_count_r <= hz_count_r;
        end else begin
            for (int k = 1; k < NSTAGES; k++) begin
                valid_r[k] <= valid_r[k-1];
                ctrl_r[k]  <= ctrl_r[k-1];
                rd_r[k]    <= rd_r[k-1];
                wen_r[k]   <= wen_r[k-1];
            end
            load_r[1] <= load_r[0];
            // Anything not accepted enters EX as an all-zero bubble
            if (accept_s) begin
                valid_r[0] <= 1'b1;
                ctrl_r[0]  <= bus.id_ctrl;
                rd_r[0]    <= bus.id_rd;
                wen_r[0]   <= bus.id_wen;
                load_r[0]  <= bus.id_load;
                rs0_r      <= bus.id_rs;
                rt0_r      <= bus.id_rt;
                use_rs0_r  <= bus.id_use_rs;
                use_rt0_r  <= bus.id_use_rt;
            end else begin
                valid_r[0] <= 1'b0;
                ctrl_r[0]  <= '0;
                rd_r[0]    <= '0;
                wen_r[0]   <= 1'b0;
                load_r[0]  <= 1'b0;
                rs0_r      <= '0;
                rt0_r      <= '0;
                use_rs0_r  <= 1'b0;
                use_rt0_r  <= 1'b0;
            end
            if (count_s && (hz_count_r != {CNT_W{1'b1}})) begin
                hz_count_r <= hz_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                hz_count_r <= hz_count_r;
            end
        end
    end

    // Forward selects: scan from the oldest stage down so the youngest match wins
    always_comb begin
        fwd_a_s = '0;
        fwd_b_s = '0;
        for (int k = NSTAGES - 1; k >= 1; k--) begin
            fwd_a_s = (valid_r[k] && wen_r[k] && (rd_r[k] != {REG_AW{1'b0}})
                       && !((k == 1) && load_r[1])
                       && use_rs0_r && (rd_r[k] == rs0_r)) ? FW'(k) : fwd_a_s;
            fwd_b_s = (valid_r[k] && wen_r[k] && (rd_r[k] != {REG_AW{1'b0}})
                       && !((k == 1) && load_r[1])
                       && use_rt0_r && (rd_r[k] == rt0_r)) ? FW'(k) : fwd_b_s;
        end
        fwd_a_s = valid_r[0] ? fwd_a_s : {FW{1'b0}};
        fwd_b_s = valid_r[0] ? fwd_b_s : {FW{1'b0}};
    end

    assign bus.stall     = rst & (bus.stall_ext | (hazard_s & ~bus.flush));
    assign bus.stg_valid = valid_r;
    assign bus.stg_ctrl  = ctrl_r;
    assign bus.fwd_a_sel = fwd_a_s;
    assign bus.fwd_b_sel = fwd_b_s;
    assign bus.wb_wen    = valid_r[NSTAGES-1] & wen_r[NSTAGES-1]
                           & (rd_r[NSTAGES-1] != {REG_AW{1'b0}});
    assign bus.wb_rd     = rd_r[NSTAGES-1];
    assign bus.hz_count  = hz_count_r;
endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Bench for pipe_ctrl_chain: directed scenario tasks plus a write-back scoreboard.
// A second instance with a 2-bit counter mirrors the stimulus to check saturation.
module tb_pipe_ctrl_chain;
    localparam int CW = 21;
    localparam int NS = 3;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_chain_if #(.CNT_W(16)) b1 ();
    pipe_ctrl_chain_if #(.CNT_W(2))  b2 ();

    pipe_ctrl_chain #(.CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(b1));
    pipe_ctrl_chain #(.CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(b2));

    assign b2.id_valid  = b1.id_valid;
    assign b2.id_ctrl   = b1.id_ctrl;
    assign b2.id_rs     = b1.id_rs;
    assign b2.id_rt     = b1.id_rt;
    assign b2.id_use_rs = b1.id_use_rs;
    assign b2.id_use_rt = b1.id_use_rt;
    assign b2.id_rd     = b1.id_rd;
    assign b2.id_wen    = b1.id_wen;
    assign b2.id_load   = b1.id_load;
    assign b2.flush     = b1.flush;
    assign b2.stall_ext = b1.stall_ext;

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [AW-1:0] rd;
        logic          wb_wen;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    wb_exp_t mon_e;
    bit      mon_adv;
    int      pass_cnt  = 0;
    int      total_cnt = 0;

    task automatic drive(input logic v, input logic [CW-1:0] c,
                         input logic [AW-1:0] rs, input logic urs,
                         input logic [AW-1:0] rt, input logic urt,
                         input logic [AW-1:0] rd, input logic wen, input logic ld);
        b1.id_valid = v;   b1.id_ctrl = c;
        b1.id_rs = rs;     b1.id_use_rs = urs;
        b1.id_rt = rt;     b1.id_use_rt = urt;
        b1.id_rd = rd;     b1.id_wen = wen;   b1.id_load = ld;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // One clock; if the bench expects the decode slot to be taken, record it for WB
    task automatic tick(input bit accept);
        wb_exp_t e;
        if (accept) begin
            e.ctrl   = b1.id_ctrl;
            e.rd     = b1.id_rd;
            e.wb_wen = b1.id_wen && (b1.id_rd != 5'd0);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Write-back monitor: each instruction seen leaving in WB must match the scoreboard
    always @(posedge clk) begin
        mon_adv = (rst === 1'b1) && (b1.stall_ext === 1'b0);
        #1;
        if (mon_adv && b1.stg_valid[NS-1] === 1'b1) begin
            total_cnt++;
            if (sb_q.size() == 0) begin
                $display("FAIL wb_unexpected: got ctrl=%h rd=%0d, scoreboard empty",
                         b1.stg_ctrl[(NS-1)*CW +: CW], b1.wb_rd);
            end else begin
                mon_e = sb_q.pop_front();
                if (b1.stg_ctrl[(NS-1)*CW +: CW] !== mon_e.ctrl || b1.wb_rd !== mon_e.rd
                    || b1.wb_wen !== mon_e.wb_wen)
                    $display("FAIL wb_retire: got ctrl=%h rd=%0d wen=%b expected ctrl=%h rd=%0d wen=%b",
                             b1.stg_ctrl[(NS-1)*CW +: CW], b1.wb_rd, b1.wb_wen,
                             mon_e.ctrl, mon_e.rd, mon_e.wb_wen);
                else pass_cnt++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        b1.flush = 1'b0;
        b1.stall_ext = 1'b1;
        drive(1'b1, 21'h1abcd, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
        tick(1'b0);
        tick(1'b0);
        total_cnt++; if (b1.stg_valid !== 3'b000) $display("FAIL rst_valid: got %b expected 000", b1.stg_valid); else pass_cnt++;
        total_cnt++; if (b1.stg_ctrl !== '0) $display("FAIL rst_ctrl: got %h expected 0", b1.stg_ctrl); else pass_cnt++;
        total_cnt++; if (b1.stall !== 1'b0) $display("FAIL rst_stall: got %b expected 0", b1.stall); else pass_cnt++;
        total_cnt++; if (b1.fwd_a_sel !== 2'd0 || b1.fwd_b_sel !== 2'd0) $display("FAIL rst_fwd: got a=%0d b=%0d expected 0 0", b1.fwd_a_sel, b1.fwd_b_sel); else pass_cnt++;
        total_cnt++; if (b1.wb_wen !== 1'b0 || b1.wb_rd !== 5'd0) $display("FAIL rst_wb: got wen=%b rd=%0d expected 0 0", b1.wb_wen, b1.wb_rd); else pass_cnt++;
        total_cnt++; if (b1.hz_count !== 16'd0) $display("FAIL rst_hz: got %0d expected 0", b1.hz_count); else pass_cnt++;
        b1.stall_ext = 1'b0;
        idle();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 21'h00111, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick(1'b1);
        drive(1'b1, 21'h00222, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0);
        total_cnt++; if (b1.stall !== 1'b0) $display("FAIL b2b_stall: got %b expected 0", b1.stall); else pass_cnt++;
        tick(1'b1);
        total_cnt++; if (b1.fwd_a_sel !== 2'd1) $display("FAIL b2b_fwd_a: got %0d expected 1", b1.fwd_a_sel); else pass_cnt++;
        total_cnt++; if (b1.fwd_b_sel !== 2'd0) $display("FAIL b2b_fwd_b0: got %0d expected 0", b1.fwd_b_sel); else pass_cnt++;
        drive(1'b1, 21'h00333, 5'd7, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0);
        tick(1'b1);
        total_cnt++; if (b1.fwd_b_sel !== 2'd2) $display("FAIL b2b_fwd_b: got %0d expected 2", b1.fwd_b_sel); else pass_cnt++;
        total_cnt++; if (b1.fwd_a_sel !== 2'd0) $display("FAIL b2b_fwd_a0: got %0d expected 0", b1.fwd_a_sel); else pass_cnt++;
        total_cnt++; if (b1.wb_wen !== 1'b1 || b1.wb_rd !== 5'd3) $display("FAIL b2b_wb: got wen=%b rd=%0d expected 1 3", b1.wb_wen, b1.wb_rd); else pass_cnt++;
        total_cnt++; if (b1.stg_valid !== 3'b111) $display("FAIL b2b_valid: got %b expected 111", b1.stg_valid); else pass_cnt++;
        idle();
        for (int i = 0; i < NS; i++) tick(1'b0);
    endtask

    task automatic test_load_use();
        drive(1'b1, 21'h0a5a5, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick(1'b1);
        drive(1'b1, 21'h05a5a, 5'd2, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0);
        total_cnt++; if (b1.stall !== 1'b1) $display("FAIL lu_stall: got %b expected 1", b1.stall); else pass_cnt++;
        tick(1'b0);
        total_cnt++; if (b1.stg_valid[0] !== 1'b0 || b1.stg_valid[1] !== 1'b1) $display("FAIL lu_bubble: got %b expected x10", b1.stg_valid); else pass_cnt++;
        total_cnt++; if (b1.stg_ctrl[0 +: CW] !== 21'h0) $display("FAIL lu_bubble_ctrl: got %h expected 0", b1.stg_ctrl[0 +: CW]); else pass_cnt++;
        total_cnt++; if (b1.hz_count !== 16'd1) $display("FAIL lu_hz: got %0d expected 1", b1.hz_count); else pass_cnt++;
        total_cnt++; if (b1.stall !== 1'b0) $display("FAIL lu_release: got %b expected 0", b1.stall); else pass_cnt++;
        tick(1'b1);
        total_cnt++; if (b1.fwd_b_sel !== 2'd2 || b1.fwd_a_sel !== 2'd0) $display("FAIL lu_fwd: got a=%0d b=%0d expected 0 2", b1.fwd_a_sel, b1.fwd_b_sel); else pass_cnt++;
        idle();
        for (int i = 0; i < NS; i++) tick(1'b0);
    endtask

    task automatic test_rd_zero();
        drive(1'b1, 21'h00c0c, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick(1'b1);
        drive(1'b1, 21'h00d0d, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        total_cnt++; if (b1.stall !== 1'b0) $display("FAIL rd0_stall: got %b expected 0", b1.stall); else pass_cnt++;
        tick(1'b1);
        total_cnt++; if (b1.fwd_a_sel !== 2'd0 || b1.fwd_b_sel !== 2'd0) $display("FAIL rd0_fwd: got a=%0d b=%0d expected 0 0", b1.fwd_a_sel, b1.fwd_b_sel); else pass_cnt++;
        idle();
        tick(1'b0);
        total_cnt++; if (b1.stg_valid[NS-1] !== 1'b1 || b1.wb_wen !== 1'b0) $display("FAIL rd0_wb: got valid=%b wen=%b expected 1 0", b1.stg_valid[NS-1], b1.wb_wen); else pass_cnt++;
        for (int i = 0; i < NS; i++) tick(1'b0);
    endtask

    task automatic test_stall_ext_flush();
        drive(1'b1, 21'h10aaa, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
        tick(1'b1);
        drive(1'b1, 21'h0bbbb, 5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
        tick(1'b1);
        b1.stall_ext = 1'b1;
        b1.flush = 1'b1;
        drive(1'b1, 21'h0cccc, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        total_cnt++; if (b1.stall !== 1'b1) $display("FAIL sx_stall: got %b expected 1", b1.stall); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            total_cnt++;
            if (b1.stg_valid !== 3'b011 || b1.stg_ctrl[0 +: CW] !== 21'h0bbbb || b1.stg_ctrl[CW +: CW] !== 21'h10aaa)
                $display("FAIL sx_hold: got valid=%b s0=%h s1=%h expected 011 0bbbb 10aaa",
                         b1.stg_valid, b1.stg_ctrl[0 +: CW], b1.stg_ctrl[CW +: CW]);
            else pass_cnt++;
        end
        b1.stall_ext = 1'b0;
        #1;
        total_cnt++; if (b1.stall !== 1'b0) $display("FAIL sx_flush_hazard_stall: got %b expected 0", b1.stall); else pass_cnt++;
        tick(1'b0);
        total_cnt++; if (b1.stg_valid !== 3'b110 || b1.stg_ctrl[0 +: CW] !== 21'h0) $display("FAIL sx_flush: got valid=%b s0=%h expected 110 0", b1.stg_valid, b1.stg_ctrl[0 +: CW]); else pass_cnt++;
        total_cnt++; if (b1.hz_count !== 16'd1) $display("FAIL sx_hz: got %0d expected 1", b1.hz_count); else pass_cnt++;
        b1.flush = 1'b0;
        idle();
        for (int i = 0; i < NS; i++) tick(1'b0);
    endtask

    task automatic test_saturation();
        int exp_sat;
        rst = 1'b0;
        sb_q.delete();
        idle();
        tick(1'b0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 21'(32'h100 + i), 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
            tick(1'b1);
            drive(1'b1, 21'(32'h200 + i), 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
            total_cnt++; if (b1.stall !== 1'b1) $display("FAIL sat_stall_%0d: got %b expected 1", i, b1.stall); else pass_cnt++;
            tick(1'b0);
            exp_sat = (i + 1 > 3) ? 3 : i + 1;
            total_cnt++; if (int'(b1.hz_count) !== i + 1) $display("FAIL sat_cnt16_%0d: got %0d expected %0d", i, b1.hz_count, i + 1); else pass_cnt++;
            total_cnt++; if (int'(b2.hz_count) !== exp_sat) $display("FAIL sat_cnt2_%0d: got %0d expected %0d", i, b2.hz_count, exp_sat); else pass_cnt++;
            tick(1'b1);
        end
        idle();
        for (int i = 0; i < NS; i++) tick(1'b0);
    endtask

    initial begin
        b1.flush = 1'b0;
        b1.stall_ext = 1'b0;
        idle();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_rd_zero();
        test_stall_ext_flush();
        test_saturation();
        total_cnt++;
        if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
